mac_kbd_link: RTL and testbench
===============================

MAC_KBD_LINK -- requirements
Module: mac_kbd_link

Interface
REQ-001 Parameter HALF_RX, default 200: ticks per clock half-period while receiving a command (host->keyboard).
REQ-002 Parameter HALF_TX, default 165: ticks per clock half-period while transmitting a response (keyboard->host).
REQ-003 Parameter REQ_FILTER, default 4: consecutive low ticks on the synchronised data line that constitute a host request.
REQ-004 Parameter RSP_TIMEOUT, default 250000: ticks allowed in WAIT_RSP before a null response is sent.
REQ-005 Ports (name, direction, width, meaning):
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- tick  in  1  one-clock enable pulse; all timing counts advance only on tick=1.
- kbd_data_i  in  1  host data line (VIA CB2 output, released=1); asynchronous.
- kbd_clk_o  out  1  keyboard clock to VIA CB1 input.
- kbd_data_o  out  1  keyboard data to VIA CB2 input.
- cmd_valid  out  1  one-clock pulse: command byte received.
- cmd_data  out  8  last received command byte.
- rsp_ready  out  1  block is accepting a response byte.
- rsp_valid  in  1  response byte offered.
- rsp_data  in  8  response byte.
- busy  out  1  high in every state except IDLE.

Function
REQ-006 kbd_data_i SHALL pass through a 2-flop synchroniser (sdata) on every clock; all decisions use sdata.
REQ-007 States SHALL be IDLE, RX_LO, RX_HI, WAIT_RSP, TX_LO, TX_HI; a 3-bit bit counter and a phase counter wide enough for RSP_TIMEOUT are used.
REQ-008 IDLE: kbd_clk_o=1, kbd_data_o=1, rsp_ready=0; the filter counter increments on each tick with sdata=0 and clears on any clock with sdata=1.
REQ-009 IDLE -> RX_LO on the tick where the filter count reaches REQ_FILTER; bit counter=7, phase counter cleared.
REQ-010 RX_LO: kbd_clk_o=0 for HALF_RX ticks, then -> RX_HI.
REQ-011 RX_HI: kbd_clk_o=1 for HALF_RX ticks; on the clock of entry to RX_HI (clock rising edge) sdata SHALL be shifted into a shift register MSB first.
REQ-012 At the end of RX_HI: bit counter>0 -> decrement, go to RX_LO; bit counter=0 -> load cmd_data from shift register, pulse cmd_valid for exactly one clock, go to WAIT_RSP.
REQ-013 kbd_data_o SHALL stay 1 throughout RX_LO/RX_HI/WAIT_RSP.
REQ-014 WAIT_RSP: rsp_ready=1; rsp_valid&&rsp_ready captures rsp_data into the TX shifter and enters TX_LO on the same clock, bit counter=7.
REQ-015 WAIT_RSP timeout: after RSP_TIMEOUT ticks without a handshake, load 8'h7B (null) and enter TX_LO; a handshake on the timeout clock wins over the null.
REQ-016 rsp_valid SHALL be ignored (no capture, no state change) outside WAIT_RSP.
REQ-017 TX_LO: on entry kbd_data_o = current MSB of TX shifter and kbd_clk_o=0; hold HALF_TX ticks, then -> TX_HI.
REQ-018 TX_HI: kbd_clk_o=1, kbd_data_o unchanged, for HALF_TX ticks; then shift left, bit counter>0 -> decrement, TX_LO; bit counter=0 -> kbd_data_o=1, IDLE.
REQ-019 Data SHALL change only at clock falling edges (TX_LO entry) and be stable throughout every high phase.
REQ-020 After returning to IDLE the filter counter SHALL be cleared so a held-low line needs a full REQ_FILTER ticks to re-trigger.
REQ-021 Timing counters SHALL not advance when tick=0; a tick during any clock without a state change only increments.

Reset
REQ-022 Reset at any time (including mid-byte) SHALL on the next clock force IDLE, kbd_clk_o=1, kbd_data_o=1, cmd_valid=0, cmd_data=8'h00, rsp_ready=0, busy=0, all counters, shifters and synchroniser flops to 0 except synchroniser flops to 1.

Verification (HALF_RX=HALF_TX=4, REQ_FILTER=2, RSP_TIMEOUT=50, tick every clock)
REQ-023 Host holds data low, shifts 8'h10 MSB first, changing only while kbd_clk_o=0 -> exactly 8 low pulses of 4 ticks, cmd_valid one clock, cmd_data=8'h10.
REQ-024 After REQ-023, rsp_valid=1 with rsp_data=8'hA5 -> rsp_ready drops next clock, kbd_data_o sampled at each kbd_clk_o rise reads 1,0,1,0,0,1,0,1, then IDLE, busy=0.
REQ-025 Command 8'h14, no response -> after 50 ticks transmits 8'h7B.
REQ-026 Single-tick low glitch on kbd_data_i in IDLE -> no clock pulses, busy stays 0.
REQ-027 Reset asserted during third TX bit -> next clock kbd_clk_o=1, kbd_data_o=1, IDLE; a subsequent request completes normally.
REQ-028 rsp_valid pulsed while in IDLE, then command received -> no spurious transmission until a new handshake in WAIT_RSP.

Source files
------------

// File: rtl/mac_kbd_link_if.sv
`default_nettype none
// ============================================================================
// Module      : mac_kbd_link_if
// Description : Command/response handshake bundle between mac_kbd_link and
//               the keyboard controller behind it.
//                 cmd_valid - one-clock pulse, a command byte was received
//                 cmd_data  - last received command byte
//                 rsp_ready - link is waiting for a response byte
//                 rsp_valid - response byte offered
//                 rsp_data  - response byte
//               slave  : the link side (drives cmd_*, rsp_ready)
//               master : the controller side (drives rsp_valid, rsp_data)
// Revision    : 1.0 - initial release
// ============================================================================
interface mac_kbd_link_if;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       rsp_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;

    modport master (
        input  cmd_valid,
        input  cmd_data,
        input  rsp_ready,
        output rsp_valid,
        output rsp_data
    );

    modport slave (
        output cmd_valid,
        output cmd_data,
        output rsp_ready,
        input  rsp_valid,
        input  rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/mac_kbd_link.sv
`default_nettype none
// ============================================================================
// Module      : mac_kbd_link
// Description : Keyboard side of the Macintosh 128K/512K keyboard link.
//               Detects a host request (data held low), clocks in an 8-bit
//               command MSB first, hands it to the controller, then clocks
//               out a response byte (or the null byte 8'h7B on timeout).
//               Ports:
//                 clock      - sole clock
//                 reset      - synchronous, active-high
//                 tick       - timing enable; all counters advance on tick
//                 kbd_data_i - host data line, asynchronous, released = 1
//                 kbd_clk_o  - keyboard clock line to host
//                 kbd_data_o - keyboard data line to host
//                 busy       - high whenever not idle
//                 bus        - command/response handshake (slave side)
// Revision    : 1.0 - initial release
// ============================================================================
module mac_kbd_link #(
    parameter int HALF_RX     = 200,
    parameter int HALF_TX     = 165,
    parameter int REQ_FILTER  = 4,
    parameter int RSP_TIMEOUT = 250000
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          tick,
    input  logic          kbd_data_i,
    output logic          kbd_clk_o,
    output logic          kbd_data_o,
    output logic          busy,
    mac_kbd_link_if.slave bus
);

    // One phase counter serves all timed states, so size it for the longest.
    localparam int c_PH_MAX_A = (HALF_RX > HALF_TX) ? HALF_RX : HALF_TX;
    localparam int c_PH_MAX   = (RSP_TIMEOUT > c_PH_MAX_A) ? RSP_TIMEOUT : c_PH_MAX_A;
    localparam int c_PHASE_W  = $clog2(c_PH_MAX + 1);
    localparam int c_FILT_W   = $clog2(REQ_FILTER + 1);

    localparam logic [c_PHASE_W-1:0] c_RX_END = c_PHASE_W'(HALF_RX - 1);
    localparam logic [c_PHASE_W-1:0] c_TX_END = c_PHASE_W'(HALF_TX - 1);
    localparam logic [c_PHASE_W-1:0] c_TO_END = c_PHASE_W'(RSP_TIMEOUT - 1);
    localparam logic [c_PHASE_W-1:0] c_PH_ONE = c_PHASE_W'(1);
    localparam logic [c_FILT_W-1:0]  c_FILT_END = c_FILT_W'(REQ_FILTER - 1);
    localparam logic [c_FILT_W-1:0]  c_FILT_ONE = c_FILT_W'(1);
    localparam logic [7:0]           c_NULL_RSP = 8'h7B;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_RX_LO = 3'd1;
    localparam logic [2:0] c_ST_RX_HI = 3'd2;
    localparam logic [2:0] c_ST_WAIT  = 3'd3;
    localparam logic [2:0] c_ST_TX_LO = 3'd4;
    localparam logic [2:0] c_ST_TX_HI = 3'd5;

    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic                 r_sync1;
    logic                 r_sdata;
    logic [c_FILT_W-1:0]  r_filt;
    logic [c_PHASE_W-1:0] r_phase;
    logic [2:0]           r_bit;
    logic [7:0]           r_rx_shift;
    logic [7:0]           r_tx_shift;
    logic [7:0]           r_cmd_data;
    logic                 r_cmd_valid;
    logic                 w_rsp_ready;
    logic                 w_hs;
    logic                 w_rx_end;
    logic                 w_tx_end;
    logic                 w_to_end;
    logic                 w_req;

    assign w_rx_end = tick && (r_phase == c_RX_END);
    assign w_tx_end = tick && (r_phase == c_TX_END);
    assign w_to_end = tick && (r_phase == c_TO_END);
    assign w_req    = tick && !r_sdata && (r_filt == c_FILT_END);
    assign w_hs     = bus.rsp_valid && w_rsp_ready;

    assign bus.cmd_valid = r_cmd_valid;
    assign bus.cmd_data  = r_cmd_data;
    assign bus.rsp_ready = w_rsp_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_req)    w_state_nxt = c_ST_RX_LO;
            c_ST_RX_LO: if (w_rx_end) w_state_nxt = c_ST_RX_HI;
            c_ST_RX_HI: if (w_rx_end) w_state_nxt = (r_bit == 3'd0) ? c_ST_WAIT : c_ST_RX_LO;
            // A handshake always wins over a coincident timeout.
            c_ST_WAIT:  if (w_hs || w_to_end) w_state_nxt = c_ST_TX_LO;
            c_ST_TX_LO: if (w_tx_end) w_state_nxt = c_ST_TX_HI;
            c_ST_TX_HI: if (w_tx_end) w_state_nxt = (r_bit == 3'd0) ? c_ST_IDLE : c_ST_TX_LO;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decoded from state. The TX data bit is the shifter MSB, which
    // only moves on the TX_HI -> TX_LO edge, so data changes only with the
    // clock falling and is stable through every high phase.
    // ------------------------------------------------------------------
    always_comb begin
        kbd_clk_o   = 1'b1;
        kbd_data_o  = 1'b1;
        w_rsp_ready = 1'b0;
        busy        = 1'b1;
        case (r_state)
            c_ST_IDLE:  busy = 1'b0;
            c_ST_RX_LO: kbd_clk_o = 1'b0;
            c_ST_WAIT:  w_rsp_ready = 1'b1;
            c_ST_TX_LO: begin
                kbd_clk_o  = 1'b0;
                kbd_data_o = r_tx_shift[7];
            end
            c_ST_TX_HI: kbd_data_o = r_tx_shift[7];
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: synchroniser, filter, counters and shifters
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1     <= 1'b1;
            r_sdata     <= 1'b1;
            r_filt      <= '0;
            r_phase     <= '0;
            r_bit       <= 3'd0;
            r_rx_shift  <= 8'h00;
            r_tx_shift  <= 8'h00;
            r_cmd_data  <= 8'h00;
            r_cmd_valid <= 1'b0;
        end else begin
            r_sync1     <= kbd_data_i;
            r_sdata     <= r_sync1;
            r_cmd_valid <= 1'b0;

            // Held outside IDLE so a still-low line after a transaction
            // needs a full filter window to re-trigger.
            if ((r_state != c_ST_IDLE) || r_sdata || (w_state_nxt != c_ST_IDLE)) begin
                r_filt <= '0;
            end else if (tick) begin
                r_filt <= r_filt + c_FILT_ONE;
            end

            if ((w_state_nxt != r_state) || (r_state == c_ST_IDLE)) begin
                r_phase <= '0;
            end else if (tick) begin
                r_phase <= r_phase + c_PH_ONE;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_state_nxt == c_ST_RX_LO) r_bit <= 3'd7;
                end
                c_ST_RX_LO: begin
                    // Sample on the clock rising edge (entry to RX_HI).
                    if (w_state_nxt == c_ST_RX_HI) r_rx_shift <= {r_rx_shift[6:0], r_sdata};
                end
                c_ST_RX_HI: begin
                    if (w_state_nxt == c_ST_RX_LO) begin
                        r_bit <= r_bit - 3'd1;
                    end else if (w_state_nxt == c_ST_WAIT) begin
                        r_cmd_data  <= r_rx_shift;
                        r_cmd_valid <= 1'b1;
                    end
                end
                c_ST_WAIT: begin
                    if (w_state_nxt == c_ST_TX_LO) begin
                        r_tx_shift <= w_hs ? bus.rsp_data : c_NULL_RSP;
                        r_bit      <= 3'd7;
                    end
                end
                c_ST_TX_HI: begin
                    if (w_state_nxt != c_ST_TX_HI) begin
                        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                        if (w_state_nxt == c_ST_TX_LO) r_bit <= r_bit - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_kbd_link.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_kbd_link
// Description : Self-checking bench for mac_kbd_link. A host model clocks
//               commands in; a line monitor counts clock pulses, measures low
//               widths, and collects data bits at each keyboard clock rise.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_kbd_link;

    localparam int c_HALF    = 4;
    localparam int c_FILTER  = 2;
    localparam int c_TIMEOUT = 50;

    logic clk        = 1'b0;
    logic rst        = 1'b1;
    logic tick       = 1'b1;
    logic kbd_data_i = 1'b1;
    logic kbd_clk_o;
    logic kbd_data_o;
    logic busy;

    mac_kbd_link_if u_if ();

    mac_kbd_link #(
        .HALF_RX    (c_HALF),
        .HALF_TX    (c_HALF),
        .REQ_FILTER (c_FILTER),
        .RSP_TIMEOUT(c_TIMEOUT)
    ) u_dut (
        .clock     (clk),
        .reset     (rst),
        .tick      (tick),
        .kbd_data_i(kbd_data_i),
        .kbd_clk_o (kbd_clk_o),
        .kbd_data_o(kbd_data_o),
        .busy      (busy),
        .bus       (u_if.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] cmd;
        bit         do_rsp;
        logic [7:0] rsp;
        logic [7:0] exp_tx;
        int         exp_lat;
    } vec_t;

    vec_t vecs[4];

    int n_checks = 0;
    int n_errors = 0;

    // Line monitor
    int         falls     = 0;
    int         rises     = 0;
    int         bad_width = 0;
    int         low_run   = 0;
    int         cv_cnt    = 0;
    int         busy_seen = 0;
    int         hi_chg    = 0;
    logic [7:0] tx_bits   = 8'h00;
    logic       prev_clk  = 1'b1;
    logic       prev_data = 1'b1;
    logic       prev_busy = 1'b0;

    always @(negedge clk) begin
        if (u_if.cmd_valid === 1'b1) cv_cnt++;
        if (busy === 1'b1) busy_seen++;
        if (kbd_clk_o === 1'b0) begin
            if (prev_clk) falls++;
            low_run++;
        end else if (!prev_clk) begin
            rises++;
            tx_bits = {tx_bits[6:0], kbd_data_o};
            if (low_run != c_HALF) bad_width++;
            low_run = 0;
        end
        if (prev_clk && (kbd_clk_o === 1'b1) && prev_busy && (busy === 1'b1) &&
            (kbd_data_o !== prev_data)) hi_chg++;
        prev_clk  = kbd_clk_o;
        prev_data = kbd_data_o;
        prev_busy = busy;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk_lvl(input logic lvl, output bit ok);
        int n;
        n  = 0;
        ok = 1'b1;
        while (kbd_clk_o !== lvl) begin
            @(negedge clk);
            n++;
            if (n > 400) begin
                ok = 1'b0;
                return;
            end
        end
    endtask

    // Host: pull data low, then present each bit while the keyboard clock is low.
    task automatic host_send(input logic [7:0] b, output bit ok);
        ok = 1'b1;
        kbd_data_i = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            wait_clk_lvl(1'b0, ok);
            if (!ok) break;
            kbd_data_i = b[i];
            wait_clk_lvl(1'b1, ok);
            if (!ok) break;
        end
        kbd_data_i = 1'b1;
    endtask

    task automatic wait_cmd(output bit ok);
        int n;
        n  = 0;
        ok = 1'b1;
        while (u_if.cmd_valid !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 400) begin
                ok = 1'b0;
                return;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        int n;
        n  = 0;
        ok = 1'b1;
        while (busy !== 1'b0) begin
            @(negedge clk);
            n++;
            if (n > 400) begin
                ok = 1'b0;
                return;
            end
        end
    endtask

    task automatic run_vector(input vec_t v);
        bit ok;
        int n;
        falls     = 0;
        bad_width = 0;
        cv_cnt    = 0;
        low_run   = 0;
        host_send(v.cmd, ok);
        check("host_clock_seen", ok, 1);
        wait_cmd(ok);
        check("cmd_valid_seen", ok, 1);
        check("cmd_data", u_if.cmd_data, v.cmd);
        check("rx_pulse_count", falls, 8);
        check("rx_pulse_width", bad_width, 0);
        check("rsp_ready_wait", u_if.rsp_ready, 1);
        rises = 0;
        if (v.do_rsp) begin
            u_if.rsp_data  = v.rsp;
            u_if.rsp_valid = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            u_if.rsp_valid = 1'b0;
        end while ((kbd_clk_o !== 1'b0) && (n < 200));
        check("tx_start_latency", n, v.exp_lat);
        check("rsp_ready_drop", u_if.rsp_ready, 0);
        wait_idle(ok);
        check("tx_end_idle", ok, 1);
        check("tx_byte", tx_bits, v.exp_tx);
        check("tx_bit_count", rises, 8);
        check("tx_pulse_width", bad_width, 0);
        check("idle_data_line", kbd_data_o, 1);
        check("idle_clk_line", kbd_clk_o, 1);
        check("cmd_valid_pulses", cv_cnt, 1);
    endtask

    initial begin : main
        bit ok;
        int n;

        vecs[0] = '{8'h10, 1'b1, 8'hA5, 8'hA5, 1};
        vecs[1] = '{8'h14, 1'b0, 8'h00, 8'h7B, c_TIMEOUT};
        vecs[2] = '{8'hFF, 1'b1, 8'h00, 8'h00, 1};
        vecs[3] = '{8'h81, 1'b1, 8'h3C, 8'h3C, 1};

        u_if.rsp_valid = 1'b0;
        u_if.rsp_data  = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_kbd_clk", kbd_clk_o, 1);
        check("rst_kbd_data", kbd_data_o, 1);
        check("rst_cmd_valid", u_if.cmd_valid, 0);
        check("rst_cmd_data", u_if.cmd_data, 8'h00);
        check("rst_rsp_ready", u_if.rsp_ready, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // One-tick low glitch must not start a transaction
        falls     = 0;
        busy_seen = 0;
        kbd_data_i = 1'b0;
        @(negedge clk);
        kbd_data_i = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_pulses", falls, 0);
        check("glitch_busy", busy_seen, 0);

        // Table of full command/response transactions
        for (int i = 0; i < 4; i++) begin
            run_vector(vecs[i]);
            repeat (5) @(negedge clk);
        end

        // Reset in the middle of the third transmitted bit
        host_send(8'h10, ok);
        check("mid_rst_host", ok, 1);
        wait_cmd(ok);
        check("mid_rst_cmd", ok, 1);
        rises = 0;
        u_if.rsp_data  = 8'hA5;
        u_if.rsp_valid = 1'b1;
        @(negedge clk);
        u_if.rsp_valid = 1'b0;
        n = 0;
        while (!((rises == 2) && (kbd_clk_o === 1'b0)) && (n < 200)) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("mid_rst_in_low_phase", kbd_clk_o, 0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_kbd_clk", kbd_clk_o, 1);
        check("mid_rst_kbd_data", kbd_data_o, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cmd_data", u_if.cmd_data, 8'h00);
        check("mid_rst_rsp_ready", u_if.rsp_ready, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        run_vector(vecs[0]);
        repeat (5) @(negedge clk);

        // rsp_valid in IDLE is ignored; WAIT_RSP holds while tick is low
        u_if.rsp_data  = 8'h55;
        u_if.rsp_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_rsp_busy", busy, 0);
        check("idle_rsp_ready", u_if.rsp_ready, 0);
        u_if.rsp_valid = 1'b0;
        falls = 0;
        host_send(8'h33, ok);
        check("late_host", ok, 1);
        wait_cmd(ok);
        check("late_cmd_seen", ok, 1);
        check("late_cmd_data", u_if.cmd_data, 8'h33);
        tick  = 1'b0;
        rises = 0;
        repeat (c_TIMEOUT + 10) @(negedge clk);
        check("notick_no_tx_clk", kbd_clk_o, 1);
        check("notick_rsp_ready", u_if.rsp_ready, 1);
        check("notick_rises", rises, 0);
        tick = 1'b1;
        u_if.rsp_data  = 8'hC3;
        u_if.rsp_valid = 1'b1;
        @(negedge clk);
        u_if.rsp_valid = 1'b0;
        check("late_hs_clk_low", kbd_clk_o, 0);
        wait_idle(ok);
        check("late_idle", ok, 1);
        check("late_tx_byte", tx_bits, 8'hC3);
        check("late_tx_bits", rises, 8);

        check("data_stable_high", hi_chg, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
